// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit:
// FSM state encoding and prefetch buffer sizing.
package fetch_pkg;

    localparam int FETCH_DEPTH = 2;
    localparam int PTR_W       = $clog2(FETCH_DEPTH);
    localparam int CNT_W       = $clog2(FETCH_DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(FETCH_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO holding {instruction, fetch address} entries.
// Flush beats push and pop; head is the oldest entry.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DATA_W = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [CNT_W-1:0]  count,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] r_mem [FETCH_DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_push;
    logic w_pop;

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    // Guards keep the pointers sane even if a caller misbehaves.
    assign w_push = push && (r_count < CNT_DEPTH);
    assign w_pop  = pop && (r_count != CNT_ZERO);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FETCH_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requests feeding
// a 2-entry prefetch buffer, with PC-relative redirect handling.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int MEM_WIDTH   = 8,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [MEM_WIDTH-1:0]   pc_addr,
    output logic                   pc_en,
    output logic                   pc_load,
    output logic [MEM_WIDTH-1:0]   pc_offset,
    output logic                   imem_req,
    output logic [MEM_WIDTH-1:0]   imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    input  logic                   redirect,
    input  logic [MEM_WIDTH-1:0]   redirect_offset,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [MEM_WIDTH-1:0]   out_pc
);

    localparam int ENTRY_W = INSTR_WIDTH + MEM_WIDTH;
    localparam logic [MEM_WIDTH-1:0] ADDR_ONE = MEM_WIDTH'(1);

    fetch_state_e         r_state;
    logic                 r_imem_req;
    logic [MEM_WIDTH-1:0] r_imem_addr;

    logic [CNT_W-1:0]   w_count;
    logic [ENTRY_W-1:0] w_head;
    logic [ENTRY_W-1:0] w_push_data;
    logic [CNT_W-1:0]   w_cnt_after_pop;
    logic [CNT_W-1:0]   w_cnt_after_push;
    logic               w_in_req;
    logic               w_push;
    logic               w_pop;

    assign w_in_req    = (r_state == ST_REQ);
    assign w_push      = w_in_req && imem_ack && !redirect;
    assign w_pop       = out_valid && out_ready;
    assign w_push_data = {imem_data, r_imem_addr};

    assign w_cnt_after_pop  = w_count - {{(CNT_W-1){1'b0}}, w_pop};
    assign w_cnt_after_push = w_cnt_after_pop + CNT_ONE;

    fetch_fifo #(
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .flush     (redirect),
        .count     (w_count),
        .head      (w_head)
    );

    // The PC update has to land in the same cycle as the ack or redirect.
    assign pc_en     = !reset && (redirect || (w_in_req && imem_ack));
    assign pc_load   = !reset && redirect;
    assign pc_offset = pc_load ? redirect_offset : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_imem_req  <= 1'b0;
            r_imem_addr <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (!redirect && (w_cnt_after_pop < CNT_DEPTH)) begin
                        r_state     <= ST_REQ;
                        r_imem_req  <= 1'b1;
                        r_imem_addr <= pc_addr;
                    end
                end
                ST_REQ: begin
                    if (redirect) begin
                        if (imem_ack) begin
                            r_state    <= ST_IDLE;
                            r_imem_req <= 1'b0;
                        end else begin
                            r_state <= ST_DROP;
                        end
                    end else if (imem_ack) begin
                        if (w_cnt_after_push < CNT_DEPTH) begin
                            r_imem_addr <= pc_addr + ADDR_ONE;
                        end else begin
                            r_state    <= ST_IDLE;
                            r_imem_req <= 1'b0;
                        end
                    end
                end
                ST_DROP: begin
                    if (imem_ack) begin
                        r_state    <= ST_IDLE;
                        r_imem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = r_imem_addr;
    assign out_valid = (w_count != CNT_ZERO);
    assign out_instr = w_head[ENTRY_W-1 -: INSTR_WIDTH];
    assign out_pc    = w_head[MEM_WIDTH-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a PC model and a
// budgeted instruction memory responder.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  pc_addr;
    logic        pc_en;
    logic        pc_load;
    logic [7:0]  pc_offset;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        redirect;
    logic [7:0]  redirect_offset;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [7:0]  out_pc;

    int n_checks = 0;
    int n_errors = 0;
    int n_pc_en  = 0;
    int budget   = 0;
    int pe0;
    bit mwait    = 1'b0;

    logic [39:0] exp_q[$];
    logic [7:0]  ack_q[$];

    fetch_unit #(
        .MEM_WIDTH   (8),
        .INSTR_WIDTH (32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_addr         (pc_addr),
        .pc_en           (pc_en),
        .pc_load         (pc_load),
        .pc_offset       (pc_offset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_data       (imem_data),
        .redirect        (redirect),
        .redirect_offset (redirect_offset),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc)
    );

    always #5 clk = ~clk;

    // Program counter owned by the environment.
    always @(posedge clk) begin
        if (reset) pc_addr <= 8'h00;
        else if (pc_en) pc_addr <= pc_load ? pc_addr + pc_offset : pc_addr + 8'h01;
    end

    // Memory: ack one cycle after a request is seen, while budget lasts.
    always @(posedge clk) begin
        #2;
        if (reset || !imem_req || imem_ack) begin
            imem_ack = 1'b0;
            mwait    = 1'b0;
        end else if (mwait && budget > 0) begin
            imem_ack  = 1'b1;
            imem_data = {24'hC0DE00, imem_addr};
            budget    = budget - 1;
        end else begin
            mwait = 1'b1;
        end
    end

    // Monitor and scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (pc_en) n_pc_en++;
            if (imem_ack && imem_req) ack_q.push_back(imem_addr);
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL sb_unexpected: got pc=%0h instr=%0h, required no output",
                             out_pc, out_instr);
                end else begin
                    logic [39:0] e;
                    e = exp_q.pop_front();
                    if ({out_instr, out_pc} !== e) begin
                        n_errors++;
                        $display("FAIL sb_entry: got %0h, required %0h",
                                 {out_instr, out_pc}, e);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [39:0] got, input logic [39:0] req);
        n_checks++;
        if (got !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_req(input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk); #1;
            if (imem_req) return;
        end
        chk("timeout_req", 40'(imem_req), 40'd1);
    endtask

    task automatic wait_acks(input int n, input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk); #1;
            if (ack_q.size() >= n) return;
        end
        chk("timeout_ack", 40'(ack_q.size()), 40'(n));
    endtask

    task automatic wait_drain(input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0) return;
        end
        chk("timeout_drain", 40'(exp_q.size()), 40'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset  = 1'b1;
        budget = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        ack_q.delete();
        n_pc_en = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},   40'(imem_req),  40'd0);
        chk({tag, "_addr"},  40'(imem_addr), 40'd0);
        chk({tag, "_valid"}, 40'(out_valid), 40'd0);
        chk({tag, "_instr"}, 40'(out_instr), 40'd0);
        chk({tag, "_pc"},    40'(out_pc),    40'd0);
        chk({tag, "_pcen"},  40'(pc_en),     40'd0);
        chk({tag, "_pcld"},  40'(pc_load),   40'd0);
        chk({tag, "_pcoff"}, 40'(pc_offset), 40'd0);
    endtask

    initial begin
        reset           = 1'b1;
        redirect        = 1'b0;
        redirect_offset = 8'h00;
        out_ready       = 1'b0;
        imem_ack        = 1'b0;
        imem_data       = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk_all_zero("rst");

        // Sequential fetch from 0x00
        @(posedge clk); #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        budget    = 3;
        exp_q.push_back({32'hC0DE0000, 8'h00});
        exp_q.push_back({32'hC0DE0001, 8'h01});
        exp_q.push_back({32'hC0DE0002, 8'h02});
        wait_acks(3, 40);
        settle(6);
        chk("seq_nack", 40'(ack_q.size()), 40'd3);
        if (ack_q.size() >= 3) begin
            chk("seq_a0", 40'(ack_q[0]), 40'h00);
            chk("seq_a1", 40'(ack_q[1]), 40'h01);
            chk("seq_a2", 40'(ack_q[2]), 40'h02);
        end
        chk("seq_pcen", 40'(n_pc_en), 40'd3);
        chk("seq_req", 40'(imem_req), 40'd1);
        chk("seq_next", 40'(imem_addr), 40'h03);
        chk("seq_pc", 40'(pc_addr), 40'h03);
        chk("seq_drain", 40'(exp_q.size()), 40'd0);

        // Redirect +5 while request at 0x03 pending
        settle(3);
        @(posedge clk); #1;
        redirect        = 1'b1;
        redirect_offset = 8'h05;
        pe0             = n_pc_en;
        @(negedge clk); #1;
        chk("rd_pcen", 40'(pc_en), 40'd1);
        chk("rd_pcld", 40'(pc_load), 40'd1);
        chk("rd_pcoff", 40'(pc_offset), 40'h05);
        @(posedge clk); #1;
        redirect        = 1'b0;
        redirect_offset = 8'h00;
        @(negedge clk); #1;
        chk("drop_req", 40'(imem_req), 40'd1);
        chk("drop_addr", 40'(imem_addr), 40'h03);
        chk("drop_pc", 40'(pc_addr), 40'h08);
        @(negedge clk);
        budget = 1;
        @(negedge clk); #1;
        chk("drop_ack", 40'(imem_ack), 40'd1);
        chk("drop_pcen", 40'(pc_en), 40'd0);
        wait_req(10);
        chk("drop_next", 40'(imem_addr), 40'h08);
        chk("drop_valid", 40'(out_valid), 40'd0);
        chk("drop_npcen", 40'(n_pc_en), 40'(pe0 + 1));

        // Backpressure: two entries then stall
        do_reset();
        out_ready = 1'b0;
        budget    = 5;
        exp_q.push_back({32'hC0DE0000, 8'h00});
        exp_q.push_back({32'hC0DE0001, 8'h01});
        settle(16);
        chk("bp_nack", 40'(ack_q.size()), 40'd2);
        chk("bp_pcen", 40'(n_pc_en), 40'd2);
        chk("bp_req", 40'(imem_req), 40'd0);
        chk("bp_valid", 40'(out_valid), 40'd1);
        chk("bp_head", 40'(out_pc), 40'h00);
        chk("bp_pcen_now", 40'(pc_en), 40'd0);
        chk("bp_pcld_now", 40'(pc_load), 40'd0);
        chk("bp_pcoff_now", 40'(pc_offset), 40'd0);
        budget = 0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk); #1;
        chk("bp_resume_req", 40'(imem_req), 40'd1);
        chk("bp_resume_addr", 40'(imem_addr), 40'h02);
        chk("bp_head2", 40'(out_pc), 40'h01);
        chk("bp_pcen2", 40'(n_pc_en), 40'd2);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_drain(10);

        // Redirect coincident with ack, wrap to 0xFF
        do_reset();
        out_ready = 1'b1;
        budget    = 1;
        exp_q.push_back({32'hC0DE0000, 8'h00});
        wait_acks(1, 20);
        settle(3);
        chk("wr_req", 40'(imem_req), 40'd1);
        chk("wr_addr", 40'(imem_addr), 40'h01);
        chk("wr_pc", 40'(pc_addr), 40'h01);
        budget = 1;
        @(posedge clk); #1;
        redirect        = 1'b1;
        redirect_offset = 8'hFE;
        @(negedge clk); #1;
        chk("wr_ack", 40'(imem_ack), 40'd1);
        chk("wr_pcen", 40'(pc_en), 40'd1);
        chk("wr_pcld", 40'(pc_load), 40'd1);
        chk("wr_pcoff", 40'(pc_offset), 40'hFE);
        @(posedge clk); #1;
        redirect        = 1'b0;
        redirect_offset = 8'h00;
        wait_req(10);
        chk("wr_next", 40'(imem_addr), 40'hFF);
        chk("wr_pcnext", 40'(pc_addr), 40'hFF);
        chk("wr_valid", 40'(out_valid), 40'd0);
        chk("wr_sb", 40'(exp_q.size()), 40'd0);

        // Reset mid-request with one entry buffered
        do_reset();
        out_ready = 1'b0;
        budget    = 1;
        wait_acks(1, 20);
        settle(3);
        chk("mr_valid", 40'(out_valid), 40'd1);
        chk("mr_req", 40'(imem_req), 40'd1);
        chk("mr_addr", 40'(imem_addr), 40'h01);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        ack_q.delete();
        @(negedge clk); #1;
        chk_all_zero("mr");
        chk("mr_pcaddr", 40'(pc_addr), 40'h00);
        exp_q.push_back({32'hC0DE0000, 8'h00});
        budget    = 1;
        out_ready = 1'b1;
        wait_drain(20);
        chk("mr_nack", 40'(ack_q.size()), 40'd1);
        if (ack_q.size() >= 1) chk("mr_a0", 40'(ack_q[0]), 40'h00);

        settle(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter MEM_WIDTH, default 8, SHALL set the instruction address width, matching the program counter.
REQ-002 Parameter INSTR_WIDTH, default 32, SHALL set the instruction word width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be synchronous, active-high reset.
REQ-005 pc_addr  input  MEM_WIDTH  SHALL be the current program counter value.
REQ-006 pc_en  output  1  SHALL be the PC enable.
REQ-007 pc_load  output  1  SHALL select PC-relative load (PC += pc_offset) instead of PC += 1.
REQ-008 pc_offset  output  MEM_WIDTH  SHALL be the relative offset applied when pc_load=1.
REQ-009 imem_req  output  1  SHALL be the instruction memory read request.
REQ-010 imem_addr  output  MEM_WIDTH  SHALL be the read address.
REQ-011 imem_ack  input  1  SHALL be the memory completion strobe, with data in the same cycle.
REQ-012 imem_data  input  INSTR_WIDTH  SHALL be the read data, valid when imem_ack=1.
REQ-013 redirect  input  1  SHALL be a one-cycle branch/jump request.
REQ-014 redirect_offset  input  MEM_WIDTH  SHALL be the offset relative to pc_addr in the redirect cycle.
REQ-015 out_valid / out_ready  output / input  1 / 1  SHALL form the decode-side valid/ready handshake.
REQ-016 out_instr / out_pc  output / output  INSTR_WIDTH / MEM_WIDTH  SHALL be the instruction and its fetch address.

Function
REQ-017 FSM states SHALL be IDLE, REQ, DROP; imem_req=1 exactly in REQ and DROP.
REQ-018 IDLE->REQ SHALL occur when no redirect is present and the buffer count after this cycle's pop is <2; imem_addr SHALL be registered from pc_addr on entry to REQ and held stable until ack.
REQ-019 A request SHALL stay asserted until imem_ack; at most one request SHALL be outstanding.
REQ-020 In REQ with imem_ack and no redirect: push {imem_data, imem_addr} into the buffer, pc_en=1 and pc_load=0 in that same cycle; next state REQ if the post-push count is <2, else IDLE.
REQ-021 A redirect SHALL drive pc_en=1, pc_load=1, pc_offset=redirect_offset combinationally in that cycle and flush the buffer, with the flush taking priority over push and pop.
REQ-022 Redirect in REQ without ack SHALL go to DROP; DROP SHALL keep the request and address held, discard the data on ack without pc_en, then go to IDLE.
REQ-023 Redirect coincident with ack SHALL discard the ack data, apply only the redirect PC update, and go to IDLE.
REQ-024 Redirect in DROP SHALL apply the PC update and remain in DROP; redirect in IDLE SHALL apply the PC update and remain in IDLE.
REQ-025 The buffer SHALL be a 2-entry FIFO; out_valid SHALL be 1 iff count>0; out_instr/out_pc SHALL show the head entry; a pop SHALL occur on out_valid&out_ready.
REQ-026 Push and pop in the same cycle SHALL leave count unchanged; overflow SHALL be impossible by REQ-018 and REQ-020.
REQ-027 pc_en, pc_load and pc_offset SHALL be 0 in every cycle with neither ack (REQ, no redirect) nor redirect.

Reset
REQ-028 Reset SHALL force state IDLE, count 0, imem_req 0, imem_addr 0, out_valid 0, out_instr 0, out_pc 0, pc_en 0, pc_load 0, pc_offset 0.
REQ-029 Reset SHALL win over redirect and ack in the same cycle; an in-flight request SHALL be abandoned, and the memory SHALL be reset with the unit.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding and the FETCH_DEPTH=2 constant.
REQ-031 The buffer SHALL be a sub-module fetch_fifo with push, pop, flush, count, and head outputs.

Verification
REQ-032 Reset, then pc_addr=0x00 and ack one cycle after each request -> imem_addr sequence 0x00,0x01,0x02, one pc_en pulse per ack, out_pc matching.
REQ-033 out_ready=0 with acks -> exactly 2 entries buffered, imem_req drops to 0, no further pc_en; one pop -> the request resumes.
REQ-034 Redirect offset 0x05 at pc_addr=0x03 with a request pending for 3 cycles -> DROP state, late ack discarded, out_valid 0, next request at 0x08.
REQ-035 Redirect and ack in the same cycle, offset 0xFE at pc_addr=0x01 -> data dropped, pc_load=1, next imem_addr 0xFF (wrap modulo 2^MEM_WIDTH).
REQ-036 Reset asserted mid-request with 1 entry buffered -> all outputs 0 next cycle, then fetch restarts from the reset PC.
